fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter PC_INC, default 16'd1: PC increment per fetched word.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: hold the IF/ID register.
REQ-006 SHALL have port branch_taken, input, 1: redirect the PC and flush.
REQ-007 SHALL have port branch_target, input, 16: redirect address.
REQ-008 SHALL have port imem_req, output, 1: instruction memory request.
REQ-009 SHALL have port imem_addr, output, 16: request address.
REQ-010 SHALL have port imem_ready, input, 1: response valid.
REQ-011 SHALL have port imem_data, input, 16: response word.
REQ-012 SHALL have ports instr_out (output, 16) and pc_out (output, 16): IF/ID instruction and its PC.
REQ-013 SHALL have port valid_out, output, 1: IF/ID holds a live instruction.
REQ-014 SHALL have ports reg1, reg2 and reg3, output, 3 each: register-bank source1, source2 and destination indices.
REQ-015 SHALL have port RegWrite, output, 1: register-bank write enable.
REQ-016 SHALL have port stall_count, output, 16: stall-cycle counter (see Configuration).

Function
REQ-017 SHALL implement states IDLE, FETCH, DROP and HOLD.
REQ-018 IDLE SHALL drive imem_req=0 and SHALL go to FETCH unconditionally on the next cycle.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=req_addr, where req_addr is the PC latched when the request was issued; req_addr SHALL stay stable until imem_ready.
REQ-020 In FETCH with imem_ready=1 and stall=0, SHALL load IF/ID with {imem_data, req_addr}, set valid_out=1, advance pc by PC_INC (mod 2^16), issue the next request from the new pc, and stay in FETCH.
REQ-021 In FETCH with imem_ready=1 and stall=1, SHALL load {imem_data, req_addr} into a one-entry skid buffer, advance pc, hold IF/ID and go to HOLD.
REQ-022 In FETCH with imem_ready=0: stall=0 SHALL set valid_out=0 (bubble) next cycle; stall=1 SHALL hold IF/ID unchanged.
REQ-023 HOLD SHALL drive imem_req=0; when stall=0, it SHALL move the skid buffer into IF/ID with valid_out=1 and go to FETCH.
REQ-024 branch_taken SHALL have priority over stall and over every response; on it, next cycle SHALL have valid_out=0, skid cleared, and pc=branch_target.
REQ-025 On branch in FETCH with imem_ready=0, SHALL go to DROP; with imem_ready=1 the response SHALL be discarded and the state SHALL stay FETCH, requesting branch_target.
REQ-026 DROP SHALL keep imem_req=1 and imem_addr=old req_addr, SHALL discard the response on imem_ready, then go to FETCH requesting pc.
REQ-027 A branch in DROP SHALL update pc only; a branch in HOLD or IDLE SHALL go to FETCH requesting branch_target.
REQ-028 Decode SHALL be combinational from IF/ID: reg3=instr_out[11:9], reg1=instr_out[8:6], reg2=instr_out[5:3], RegWrite=valid_out and instr_out[15]==0.
REQ-029 pc SHALL wrap: 16'hFFFF+PC_INC(1) -> 16'h0000.

Reset
REQ-030 Reset SHALL set state=IDLE, pc=RESET_PC, req_addr=RESET_PC, valid_out=0, instr_out=0, pc_out=0, skid empty, stall_count=0; imem_req SHALL be 0 while reset is high.
REQ-031 Reset mid-request SHALL abandon the outstanding request; a response arriving during or after reset, before the first new request, SHALL be ignored.

Configuration
REQ-032 With FETCH_STALL_CNT_EN defined, stall_count SHALL increment, saturating at 16'hFFFF, every cycle stall=1 and valid_out=1.
REQ-033 Without FETCH_STALL_CNT_EN, stall_count SHALL be tied to 16'h0000 and SHALL have no counter logic.

Verification
REQ-034 Reset, then imem_ready held 1 with data 16'h0A48 at address 0 -> instr_out=16'h0A48, pc_out=0, valid_out=1, reg3=5, reg1=1, reg2=1, RegWrite=1; next imem_addr=1.
REQ-035 stall=1 for 3 cycles while a response arrives -> HOLD entered, imem_req=0, IF/ID unchanged; after stall drops, the skid word appears at the next edge; stall_count=3 when the macro is defined, 0 when it is not.
REQ-036 branch_taken with target 16'h0040 while a request to 5 is pending -> DROP, imem_addr stays 5, the response is discarded, then imem_addr=16'h0040 and valid_out stays 0 until that response.
REQ-037 branch and stall on the same cycle -> flush wins: valid_out=0 and pc=target.
REQ-038 pc at 16'hFFFF fetches -> next imem_addr=16'h0000.
REQ-039 Reset asserted during FETCH with imem_ready=1 -> no IF/ID load, valid_out=0, imem_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one outstanding imem request, IF/ID register with skid buffer.
// Optional stall-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic [2:0]  reg1,
  output logic [2:0]  reg2,
  output logic [2:0]  reg3,
  output logic        RegWrite,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] req_addr, req_addr_n;
  logic [15:0] instr_n, pc_out_n;
  logic        valid_n;
  logic [15:0] skid_instr, skid_instr_n;
  logic [15:0] skid_pc, skid_pc_n;
  logic [15:0] pc_seq;

  assign pc_seq = pc + PC_INC;

  // HOLD doubles as the skid-occupied flag, so leaving HOLD empties the skid.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    instr_n      = instr_out;
    pc_out_n     = pc_out;
    valid_n      = valid_out;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    case (state)
      IDLE: begin
        state_n    = FETCH;
        req_addr_n = pc;
        if (branch_taken) begin
          pc_n       = branch_target;
          req_addr_n = branch_target;
          valid_n    = 1'b0;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          pc_n    = branch_target;
          if (imem_ready) req_addr_n = branch_target;
          else            state_n    = DROP;
        end else if (imem_ready) begin
          pc_n       = pc_seq;
          req_addr_n = pc_seq;
          if (stall) begin
            skid_instr_n = imem_data;
            skid_pc_n    = req_addr;
            state_n      = HOLD;
          end else begin
            instr_n  = imem_data;
            pc_out_n = req_addr;
            valid_n  = 1'b1;
          end
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end
      DROP: begin
        // The old request stays on the bus until its response is thrown away.
        if (branch_taken) begin
          pc_n    = branch_target;
          valid_n = 1'b0;
        end
        if (imem_ready) begin
          state_n    = FETCH;
          req_addr_n = pc_n;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_n       = branch_target;
          req_addr_n = branch_target;
          valid_n    = 1'b0;
          state_n    = FETCH;
        end else if (!stall) begin
          instr_n    = skid_instr;
          pc_out_n   = skid_pc;
          valid_n    = 1'b1;
          req_addr_n = pc;
          state_n    = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      instr_out  <= 16'h0000;
      pc_out     <= 16'h0000;
      valid_out  <= 1'b0;
      skid_instr <= 16'h0000;
      skid_pc    <= 16'h0000;
    end else begin
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      instr_out  <= instr_n;
      pc_out     <= pc_out_n;
      valid_out  <= valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  assign imem_req  = !reset && (state == FETCH || state == DROP);
  assign imem_addr = req_addr;

  assign reg3     = instr_out[11:9];
  assign reg1     = instr_out[8:6];
  assign reg2     = instr_out[5:3];
  assign RegWrite = valid_out && !instr_out[15];

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= 16'h0000;
    else if (stall && valid_out && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'd1;
`ifdef FETCH_STALL_CNT_EN
  localparam logic [15:0] EXP_CNT3 = 16'd3;
`else
  localparam logic [15:0] EXP_CNT3 = 16'd0;
`endif

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic [2:0]  reg1, reg2, reg3;
  logic        RegWrite;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding-request flag, a discard flag and a skid queue.
  logic [15:0] m_pc, m_req_addr, m_instr, m_pcout, m_cnt;
  logic        m_valid, m_idle, m_outstanding, m_discard;
  logic [31:0] m_skid[$];

  fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .RegWrite(RegWrite),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [31:0] resp;
    if (reset) begin
      m_pc = RESET_PC; m_req_addr = RESET_PC;
      m_instr = 16'h0000; m_pcout = 16'h0000; m_valid = 1'b0; m_cnt = 16'h0000;
      m_idle = 1'b1; m_outstanding = 1'b0; m_discard = 1'b0;
      m_skid.delete();
    end else begin
`ifdef FETCH_STALL_CNT_EN
      if (stall && m_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      if (m_idle) begin
        m_idle = 1'b0;
        if (branch_taken) begin m_pc = branch_target; m_valid = 1'b0; end
        m_req_addr = m_pc; m_outstanding = 1'b1; m_discard = 1'b0;
      end else if (m_skid.size() > 0) begin
        if (branch_taken) begin
          m_skid.delete(); m_valid = 1'b0; m_pc = branch_target;
          m_req_addr = m_pc; m_outstanding = 1'b1;
        end else if (!stall) begin
          resp = m_skid.pop_front();
          m_instr = resp[31:16]; m_pcout = resp[15:0]; m_valid = 1'b1;
          m_req_addr = m_pc; m_outstanding = 1'b1;
        end
      end else if (m_discard) begin
        if (branch_taken) begin m_pc = branch_target; m_valid = 1'b0; end
        if (imem_ready) begin m_discard = 1'b0; m_req_addr = m_pc; end
      end else begin
        if (branch_taken) begin
          m_valid = 1'b0; m_pc = branch_target;
          if (imem_ready) m_req_addr = m_pc;
          else            m_discard = 1'b1;
        end else if (imem_ready) begin
          resp = {imem_data, m_req_addr};
          m_pc = m_pc + PC_INC;
          if (stall) begin
            m_skid.push_back(resp); m_outstanding = 1'b0;
          end else begin
            m_instr = resp[31:16]; m_pcout = resp[15:0]; m_valid = 1'b1;
            m_req_addr = m_pc;
          end
        end else if (!stall) begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic checkAll();
    logic exp_req;
    logic exp_rw;
    exp_req = m_outstanding && !reset;
    exp_rw  = m_valid && (m_instr < 16'h8000);
    checkOutput("valid_out", {15'd0, valid_out}, {15'd0, m_valid});
    checkOutput("instr_out", instr_out, m_instr);
    checkOutput("pc_out", pc_out, m_pcout);
    checkOutput("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
    if (exp_req) checkOutput("imem_addr", imem_addr, m_req_addr);
    checkOutput("reg3", {13'd0, reg3}, (m_instr / 16'd512) % 16'd8);
    checkOutput("reg1", {13'd0, reg1}, (m_instr / 16'd64) % 16'd8);
    checkOutput("reg2", {13'd0, reg2}, (m_instr / 16'd8) % 16'd8);
    checkOutput("RegWrite", {15'd0, RegWrite}, {15'd0, exp_rw});
    checkOutput("stall_count", stall_count, m_cnt);
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic br,
                               input logic [15:0] tgt, input logic rdy, input logic [15:0] dat);
    reset = rst; stall = st; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_data = dat;
    @(posedge clock);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;

    // Reset with a stray response on the bus, then a response during IDLE.
    applyStimulus(1, 0, 0, 16'h0, 1, 16'hBEEF);
    applyStimulus(1, 0, 0, 16'h0, 1, 16'hBEEF);
    checkOutput("rst_valid", {15'd0, valid_out}, 16'd0);
    checkOutput("rst_req", {15'd0, imem_req}, 16'd0);
    checkOutput("rst_cnt", stall_count, 16'd0);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'hBEEF);
    checkOutput("idle_ignored", {15'd0, valid_out}, 16'd0);
    checkOutput("first_addr", imem_addr, RESET_PC);

    // First fetch and decode.
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h0A48);
    checkOutput("f0_instr", instr_out, 16'h0A48);
    checkOutput("f0_pc", pc_out, 16'h0000);
    checkOutput("f0_reg3", {13'd0, reg3}, 16'd5);
    checkOutput("f0_reg1", {13'd0, reg1}, 16'd1);
    checkOutput("f0_reg2", {13'd0, reg2}, 16'd1);
    checkOutput("f0_rw", {15'd0, RegWrite}, 16'd1);
    checkOutput("f0_next_addr", imem_addr, 16'h0001);

    // Stall while a response lands: skid, then release.
    applyStimulus(0, 1, 0, 16'h0, 1, 16'h1234);
    checkOutput("hold_req", {15'd0, imem_req}, 16'd0);
    checkOutput("hold_instr", instr_out, 16'h0A48);
    applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("hold_cnt", stall_count, EXP_CNT3);
    applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("skid_instr", instr_out, 16'h1234);
    checkOutput("skid_pc", pc_out, 16'h0001);

    // Advance to address 5, then branch while that request is pending.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 16'h0, 1, 16'(16'h2000 + i));
    checkOutput("pre_branch_addr", imem_addr, 16'h0005);
    applyStimulus(0, 0, 1, 16'h0040, 0, 16'h0);
    checkOutput("drop_addr", imem_addr, 16'h0005);
    checkOutput("drop_valid", {15'd0, valid_out}, 16'd0);
    applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'hDEAD);
    checkOutput("drop_discard", {15'd0, valid_out}, 16'd0);
    checkOutput("redirect_addr", imem_addr, 16'h0040);
    applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h8001);
    checkOutput("target_instr", instr_out, 16'h8001);
    checkOutput("target_pc", pc_out, 16'h0040);
    checkOutput("target_rw", {15'd0, RegWrite}, 16'd0);

    // Branch and stall together: flush wins.
    applyStimulus(0, 1, 1, 16'h0100, 0, 16'h0);
    checkOutput("flush_valid", {15'd0, valid_out}, 16'd0);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h0);
    checkOutput("flush_addr", imem_addr, 16'h0100);

    // PC wrap.
    applyStimulus(0, 0, 1, 16'hFFFF, 1, 16'h0);
    checkOutput("wrap_pre", imem_addr, 16'hFFFF);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h7777);
    checkOutput("wrap_pc", pc_out, 16'hFFFF);
    checkOutput("wrap_addr", imem_addr, 16'h0000);

    // Reset during an accepted response.
    applyStimulus(1, 0, 0, 16'h0, 1, 16'h5555);
    checkOutput("rst_mid_valid", {15'd0, valid_out}, 16'd0);
    checkOutput("rst_mid_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(0, 0, 0, 16'h0, 1, 16'h5555);
    checkOutput("rst_mid_addr", imem_addr, RESET_PC);
    checkOutput("rst_mid_valid2", {15'd0, valid_out}, 16'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0,
                    16'($urandom),
                    $urandom_range(0, 1) == 1,
                    16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
